serial_adder: RTL and testbench
===============================

// Module: serial_adder
//
// PURPOSE
//  Multi-cycle bit-serial adder/subtractor. Processes DIGIT bits per clock
//  through one DIGIT-bit full-adder slice with a registered carry. Trades
//  latency for area; used as the arithmetic unit of the COA datapath
//  exercises. Start/busy/done handshake, result held until the next start.
//
// PARAMETERS
//  WIDTH  8  operand and sum width in bits (>=1)
//  DIGIT  1  bits added per cycle; WIDTH % DIGIT must be 0 (elaboration error otherwise)
//
// PORTS
//  clk       in   1      single clock, all state on rising edge
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request; sampled only in IDLE or DONE
//  sub       in   1      0: op1+op2+cin; 1: op1+~op2+1 (cin ignored)
//  op1       in   WIDTH  operand A, captured when start is accepted
//  op2       in   WIDTH  operand B, captured when start is accepted
//  cin       in   1      carry-in, captured when start is accepted
//  busy      out  1      high while in RUN
//  done      out  1      one-cycle pulse, result valid
//  sum       out  WIDTH  result, registered, held until the next done
//  cout      out  1      carry out of MSB (sub: 1 = no borrow)
//  overflow  out  1      signed overflow = carry into MSB ^ carry out of MSB
//
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE, busy=0, done=0, sum=0, cout=0,
//    overflow=0, internal shift regs, carry and counter cleared. Reset has
//    priority over every other input and aborts any operation in progress.
//  - FSM: IDLE -(start)-> RUN -(last digit)-> DONE -(start)-> RUN,
//    DONE -(!start)-> IDLE. DONE lasts exactly one cycle.
//  - Accept: in IDLE/DONE with start=1, latch op1, op2^{WIDTH{sub}}, carry=sub?1:cin,
//    counter=0. start while RUN is ignored (no queueing, operands not re-latched).
//  - RUN: each cycle add the low DIGIT bits of both shift regs plus carry;
//    shift result into a partial-sum reg from the top; shift operands right
//    by DIGIT; register carry; counter++. After WIDTH/DIGIT cycles -> DONE.
//  - Output update: sum/cout/overflow load on the RUN->DONE edge only;
//    unchanged at all other times (partial sums never visible).
//  - Latency: start sampled at edge E -> done=1 during the cycle after edge
//    E+WIDTH/DIGIT. WIDTH=8,DIGIT=1: 8 RUN cycles; back-to-back start in
//    DONE gives a throughput of one result per WIDTH/DIGIT+1 cycles.
//  - busy=1 exactly in RUN; done=1 exactly in DONE; never both.
//  - WIDTH=1,DIGIT=1 degenerates to a registered full adder (sum=s, cout=c).
//  - Overflow uses the carry into bit WIDTH-1, tracked inside the final digit.
//
// TESTING
//  1. W=8,D=1: op1=0x5A op2=0x3C cin=0 sub=0 -> sum=0x96 cout=0 overflow=1, done 8 cycles after accept
//  2. W=8,D=1: op1=0xFF op2=0x01 cin=0 -> sum=0x00 cout=1 overflow=0; cin=1 -> sum=0x01 cout=1
//  3. W=8,D=1: sub=1 op1=0x10 op2=0x20 cin=1 -> sum=0xF0 cout=0 overflow=0 (cin ignored)
//  4. start held high through RUN with new operands -> first result unchanged, second op starts from DONE
//  5. rst=1 at 4th RUN cycle -> next cycle busy=0 done=0 sum=0; fresh start 0x01+0x01 -> 0x02
//  6. W=8,D=4: op1=0xFF op2=0xFF cin=1 -> sum=0xFF cout=1 overflow=0, done 2 cycles after accept; W=1: all 8 full-adder vectors

Source files
------------

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake bundle for the bit-serial adder.
// The requester drives operands and start; the adder returns status and result.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, sub, op1, op2, cin,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, sub, op1, op2, cin,
      output busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: DIGIT bits per cycle through one slice
// with a registered carry, result held until the next operation ends.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic         clk,
   input  logic         rst,
   serial_adder_if.slave bus
);

   if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad
      $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
   end

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           nstate;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] psum;
   logic [WIDTH-1:0] psum_nx;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             accept;
   logic [DIGIT-1:0] s;
   logic [DIGIT:0]   cv;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   assign last   = (cnt == CW'(N - 1));
   assign accept = (state != RUN) && bus.start;

   // One DIGIT-wide ripple slice; cv[DIGIT-1] is the carry into the MSB
   // when this is the final digit.
   always_comb begin
      cv    = '0;
      s     = '0;
      cv[0] = carry;
      for (int i = 0; i < DIGIT; i++) begin
         s[i]    = a[i] ^ b[i] ^ cv[i];
         cv[i+1] = (a[i] & b[i]) | (cv[i] & (a[i] ^ b[i]));
      end
   end

   // New digits enter from the top so the final shift lands bit 0 at bit 0.
   assign psum_nx = (psum >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nstate;
      end
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (bus.start) nstate = RUN;
         RUN:     if (last) nstate = DONE;
         DONE:    nstate = bus.start ? RUN : IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      bus.busy     = (state == RUN);
      bus.done     = (state == DONE);
      bus.sum      = sum_q;
      bus.cout     = cout_q;
      bus.overflow = ovf_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a      <= '0;
         b      <= '0;
         psum   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         a     <= bus.op1;
         b     <= bus.op2 ^ {WIDTH{bus.sub}};
         carry <= bus.sub ? 1'b1 : bus.cin;
         psum  <= '0;
         cnt   <= '0;
      end else if (state == RUN) begin
         a     <= a >> DIGIT;
         b     <= b >> DIGIT;
         psum  <= psum_nx;
         carry <= cv[DIGIT];
         cnt   <= cnt + 1'b1;
         if (last) begin
            sum_q  <= psum_nx;
            cout_q <= cv[DIGIT];
            ovf_q  <= cv[DIGIT-1] ^ cv[DIGIT];
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: W8/D1, W8/D4 and W1/D1 instances
// sharing one clock and reset.
module tb_serial_adder;

   logic clk;
   logic rst;
   int   checks;
   int   fails;

   serial_adder_if #(.WIDTH(8)) b8();
   serial_adder_if #(.WIDTH(8)) b84();
   serial_adder_if #(.WIDTH(1)) b1();

   serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
      .clk(clk), .rst(rst), .bus(b8)
   );
   serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (
      .clk(clk), .rst(rst), .bus(b84)
   );
   serial_adder #(.WIDTH(1), .DIGIT(1)) u1 (
      .clk(clk), .rst(rst), .bus(b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run8(input logic [7:0] x, input logic [7:0] y,
                       input logic c, input logic sb, output int lat);
      b8.op1 = x; b8.op2 = y; b8.cin = c; b8.sub = sb;
      b8.start = 1'b1;
      step();
      b8.start = 1'b0;
      lat = 0;
      while (!b8.done && lat < 40) begin
         step();
         lat++;
      end
   endtask

   task automatic run84(input logic [7:0] x, input logic [7:0] y,
                        input logic c, output int lat);
      b84.op1 = x; b84.op2 = y; b84.cin = c; b84.sub = 1'b0;
      b84.start = 1'b1;
      step();
      b84.start = 1'b0;
      lat = 0;
      while (!b84.done && lat < 40) begin
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++;
      if (b8.busy !== 1'b0 || b8.done !== 1'b0) begin
         fails++;
         $display("FAIL reset_hs busy=%b done=%b want 0 0", b8.busy, b8.done);
      end
      checks++;
      if (b8.sum !== 8'h00 || b8.cout !== 1'b0 || b8.overflow !== 1'b0) begin
         fails++;
         $display("FAIL reset_out sum=%h c=%b v=%b want 00 0 0",
                  b8.sum, b8.cout, b8.overflow);
      end
      checks++;
      if (b84.busy !== 1'b0 || b84.done !== 1'b0 || b84.sum !== 8'h00) begin
         fails++;
         $display("FAIL reset_d4 busy=%b done=%b sum=%h want 0 0 00",
                  b84.busy, b84.done, b84.sum);
      end
   endtask

   task automatic test_add();
      int lat;
      b8.op1 = 8'h5A; b8.op2 = 8'h3C; b8.cin = 1'b0; b8.sub = 1'b0;
      b8.start = 1'b1;
      step();
      b8.start = 1'b0;
      checks++;
      if (b8.busy !== 1'b1 || b8.done !== 1'b0) begin
         fails++;
         $display("FAIL add_busy busy=%b done=%b want 1 0", b8.busy, b8.done);
      end
      lat = 0;
      while (!b8.done && lat < 40) begin
         step();
         lat++;
         if (lat == 4) begin
            checks++;
            if (b8.sum !== 8'h00) begin
               fails++;
               $display("FAIL add_hidden sum=%h want 00 mid-run", b8.sum);
            end
         end
      end
      checks++;
      if (lat !== 8) begin
         fails++;
         $display("FAIL add_lat got=%0d want 8", lat);
      end
      checks++;
      if (b8.sum !== 8'h96 || b8.cout !== 1'b0 || b8.overflow !== 1'b1) begin
         fails++;
         $display("FAIL add_5a3c sum=%h c=%b v=%b want 96 0 1",
                  b8.sum, b8.cout, b8.overflow);
      end
      checks++;
      if (b8.busy !== 1'b0) begin
         fails++;
         $display("FAIL add_excl busy=%b want 0 with done", b8.busy);
      end
      step();
      checks++;
      if (b8.done !== 1'b0 || b8.busy !== 1'b0 || b8.sum !== 8'h96) begin
         fails++;
         $display("FAIL add_idle done=%b busy=%b sum=%h want 0 0 96",
                  b8.done, b8.busy, b8.sum);
      end
   endtask

   task automatic test_carry();
      int lat;
      run8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
      checks++;
      if (lat !== 8 || b8.sum !== 8'h00 || b8.cout !== 1'b1
          || b8.overflow !== 1'b0) begin
         fails++;
         $display("FAIL wrap lat=%0d sum=%h c=%b v=%b want 8 00 1 0",
                  lat, b8.sum, b8.cout, b8.overflow);
      end
      step();
      run8(8'hFF, 8'h01, 1'b1, 1'b0, lat);
      checks++;
      if (b8.sum !== 8'h01 || b8.cout !== 1'b1 || b8.overflow !== 1'b0) begin
         fails++;
         $display("FAIL wrap_cin sum=%h c=%b v=%b want 01 1 0",
                  b8.sum, b8.cout, b8.overflow);
      end
      step();
   endtask

   task automatic test_sub();
      int lat;
      run8(8'h10, 8'h20, 1'b1, 1'b1, lat);
      checks++;
      if (b8.sum !== 8'hF0 || b8.cout !== 1'b0 || b8.overflow !== 1'b0) begin
         fails++;
         $display("FAIL sub sum=%h c=%b v=%b want f0 0 0",
                  b8.sum, b8.cout, b8.overflow);
      end
      step();
      run8(8'h80, 8'h01, 1'b0, 1'b1, lat);
      checks++;
      if (b8.sum !== 8'h7F || b8.cout !== 1'b1 || b8.overflow !== 1'b1) begin
         fails++;
         $display("FAIL sub_ovf sum=%h c=%b v=%b want 7f 1 1",
                  b8.sum, b8.cout, b8.overflow);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int lat;
      b8.op1 = 8'h01; b8.op2 = 8'h02; b8.cin = 1'b0; b8.sub = 1'b0;
      b8.start = 1'b1;
      step();
      b8.op1 = 8'h10; b8.op2 = 8'h20;
      lat = 0;
      while (!b8.done && lat < 40) begin
         step();
         lat++;
      end
      checks++;
      if (lat !== 8 || b8.sum !== 8'h03) begin
         fails++;
         $display("FAIL b2b_first lat=%0d sum=%h want 8 03", lat, b8.sum);
      end
      step();
      b8.start = 1'b0;
      checks++;
      if (b8.busy !== 1'b1 || b8.done !== 1'b0 || b8.sum !== 8'h03) begin
         fails++;
         $display("FAIL b2b_restart busy=%b done=%b sum=%h want 1 0 03",
                  b8.busy, b8.done, b8.sum);
      end
      lat = 0;
      while (!b8.done && lat < 40) begin
         step();
         lat++;
      end
      checks++;
      if (lat !== 8 || b8.sum !== 8'h30) begin
         fails++;
         $display("FAIL b2b_second lat=%0d sum=%h want 8 30", lat, b8.sum);
      end
      step();
   endtask

   task automatic test_abort();
      int lat;
      b8.op1 = 8'h55; b8.op2 = 8'h0A; b8.cin = 1'b0; b8.sub = 1'b0;
      b8.start = 1'b1;
      step();
      b8.start = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (b8.busy !== 1'b0 || b8.done !== 1'b0 || b8.sum !== 8'h00) begin
         fails++;
         $display("FAIL abort busy=%b done=%b sum=%h want 0 0 00",
                  b8.busy, b8.done, b8.sum);
      end
      run8(8'h01, 8'h01, 1'b0, 1'b0, lat);
      checks++;
      if (lat !== 8 || b8.sum !== 8'h02 || b8.cout !== 1'b0) begin
         fails++;
         $display("FAIL abort_fresh lat=%0d sum=%h c=%b want 8 02 0",
                  lat, b8.sum, b8.cout);
      end
      step();
   endtask

   task automatic test_digit4();
      int lat;
      run84(8'hFF, 8'hFF, 1'b1, lat);
      checks++;
      if (lat !== 2) begin
         fails++;
         $display("FAIL d4_lat got=%0d want 2", lat);
      end
      checks++;
      if (b84.sum !== 8'hFF || b84.cout !== 1'b1 || b84.overflow !== 1'b0) begin
         fails++;
         $display("FAIL d4_ff sum=%h c=%b v=%b want ff 1 0",
                  b84.sum, b84.cout, b84.overflow);
      end
      step();
      run84(8'h7F, 8'h01, 1'b0, lat);
      checks++;
      if (b84.sum !== 8'h80 || b84.cout !== 1'b0 || b84.overflow !== 1'b1) begin
         fails++;
         $display("FAIL d4_ovf sum=%h c=%b v=%b want 80 0 1",
                  b84.sum, b84.cout, b84.overflow);
      end
      step();
   endtask

   task automatic test_width1();
      logic [2:0] v;
      logic [7:0] exp_s;
      logic [7:0] exp_c;
      int         lat;
      // Truth table of the full adder, indexed by {a,b,cin}.
      exp_s = 8'b1001_0110;
      exp_c = 8'b1110_1000;
      for (int k = 0; k < 8; k++) begin
         v = 3'(k);
         b1.op1 = v[2]; b1.op2 = v[1]; b1.cin = v[0]; b1.sub = 1'b0;
         b1.start = 1'b1;
         step();
         b1.start = 1'b0;
         lat = 0;
         while (!b1.done && lat < 10) begin
            step();
            lat++;
         end
         checks++;
         if (lat !== 1 || b1.sum !== exp_s[k] || b1.cout !== exp_c[k]
             || b1.overflow !== (exp_c[k] ^ v[0])) begin
            fails++;
            $display("FAIL w1_%0d lat=%0d s=%b c=%b v=%b want 1 %b %b %b",
                     k, lat, b1.sum, b1.cout, b1.overflow,
                     exp_s[k], exp_c[k], exp_c[k] ^ v[0]);
         end
         step();
      end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      rst    = 1'b1;
      b8.start  = 1'b0; b8.sub  = 1'b0; b8.cin  = 1'b0;
      b8.op1    = '0;   b8.op2  = '0;
      b84.start = 1'b0; b84.sub = 1'b0; b84.cin = 1'b0;
      b84.op1   = '0;   b84.op2 = '0;
      b1.start  = 1'b0; b1.sub  = 1'b0; b1.cin  = 1'b0;
      b1.op1    = '0;   b1.op2  = '0;
      test_reset();
      test_add();
      test_carry();
      test_sub();
      test_back_to_back();
      test_abort();
      test_digit4();
      test_width1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
